// File: rtl/block_loader_if.sv
// block_loader_if: start, block position ROM and block handshake bundle for block_loader.
interface block_loader_if #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 5
);
    logic                    start;
    logic [ADDR_WIDTH-1:0]   rom_addr;
    logic [WIDTH-1:0]        rom_q;
    logic                    blk_valid;
    logic                    blk_ready;
    logic [ADDR_WIDTH-1:0]   blk_index;
    logic [WIDTH/2-1:0]      blk_x;
    logic [WIDTH/2-1:0]      blk_y;
    logic                    busy;
    logic                    done;
    logic [ADDR_WIDTH:0]     count;

    modport master (
        input  start, rom_q, blk_ready,
        output rom_addr, blk_valid, blk_index, blk_x, blk_y, busy, done, count
    );

    modport slave (
        output start, rom_q, blk_ready,
        input  rom_addr, blk_valid, blk_index, blk_x, blk_y, busy, done, count
    );
endinterface

// File: rtl/block_loader.sv
// block_loader: walks the block position ROM and offers each entry downstream until the terminator or the last address.
module block_loader #(
    parameter int               WIDTH      = 10,
    parameter int               ADDR_WIDTH = 5,
    parameter logic [WIDTH-1:0] TERMINATOR = '1
) (
    input logic           clk,
    input logic           reset,
    block_loader_if.master bus
);
    localparam int HW = WIDTH / 2;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, OFFER, DONE} state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr, index;
    logic [HW-1:0]         x, y;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  is_term, accept;

    assign is_term = bus.rom_q == TERMINATOR;
    assign accept  = state == OFFER && bus.blk_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.start ? FETCH : IDLE;
            FETCH:   next_state = CAPTURE;
            CAPTURE: next_state = is_term ? DONE : OFFER;
            OFFER:   next_state = !bus.blk_ready ? OFFER : (addr == '1 ? DONE : FETCH);
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            index <= '0;
            x     <= '0;
            y     <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.start) begin
                addr <= '0;
                cnt  <= '0;
            end
            if (state == CAPTURE && !is_term) begin
                x     <= bus.rom_q[HW-1:0];
                y     <= bus.rom_q[WIDTH-1:HW];
                index <= addr;
            end
            // the last address ends the load instead of wrapping back to 0
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (addr != '1)
                    addr <= addr + 1'b1;
            end
        end
    end

    assign bus.rom_addr  = addr;
    assign bus.blk_valid = state == OFFER;
    assign bus.blk_index = index;
    assign bus.blk_x     = x;
    assign bus.blk_y     = y;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_block_loader.sv
// tb_block_loader: table-driven loads against a synchronous model ROM plus reset, start-ignore and full-table sequences.
module tb_block_loader;
    localparam int W  = 10;
    localparam int AW = 5;

    typedef struct {
        logic [W-1:0] w0, w1, w2;
        int           stall;
        int           exp_cnt;
        int           exp_cyc;
        logic [4:0]   x0, y0;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] rom [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    block_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus();
    block_loader #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always_ff @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
        for (int i = 0; i < 32; i++) rom[i] = '1;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    // Pulses start, stalls the first offer for 'stall' cycles and checks every accepted entry against the ROM.
    task automatic run_load(input int stall, input bit poke, output int cyc, output int acc,
                            output logic [4:0] fx, output logic [4:0] fy);
        int left;
        bit stalled, wrap, fin;
        logic [4:0] sx, sy, si;
        left = stall; stalled = 0; wrap = 0; fin = 0; acc = 0; cyc = 0;
        fx = '0; fy = '0; sx = '0; sy = '0; si = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.blk_ready = 1'b1;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (stalled) begin
                chk("hold_valid", 32'(bus.blk_valid), 32'd1);
                chk("hold_x", 32'(bus.blk_x), 32'(sx));
                chk("hold_y", 32'(bus.blk_y), 32'(sy));
                chk("hold_idx", 32'(bus.blk_index), 32'(si));
            end
            stalled = 0;
            if (acc > 0 && bus.rom_addr == '0) wrap = 1;
            if (bus.done) fin = 1;
            else if (bus.blk_valid) begin
                if (poke) bus.start = 1'b1;
                if (left > 0) begin
                    left--;
                    bus.blk_ready = 1'b0;
                    stalled = 1;
                    sx = bus.blk_x; sy = bus.blk_y; si = bus.blk_index;
                end else begin
                    bus.blk_ready = 1'b1;
                    if (acc == 0) begin fx = bus.blk_x; fy = bus.blk_y; end
                    chk("acc_idx", 32'(bus.blk_index), 32'(acc));
                    chk("acc_x", 32'(bus.blk_x), 32'(rom[acc][4:0]));
                    chk("acc_y", 32'(bus.blk_y), 32'(rom[acc][9:5]));
                    acc++;
                end
            end else
                bus.blk_ready = 1'($urandom_range(0, 1));
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        if (poke) bus.start = 1'b1;
        chk("no_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.blk_ready = 1'b0;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t vecs [5];
        int cyc, acc, seen;
        logic [4:0] fx, fy;
        vecs[0] = '{10'h021, 10'h043, 10'h3FF, 0, 2,  9, 5'd1,  5'd1};
        vecs[1] = '{10'h021, 10'h043, 10'h3FF, 5, 2, 14, 5'd1,  5'd1};
        vecs[2] = '{10'h3FF, 10'h021, 10'h043, 0, 0,  3, 5'd0,  5'd0};
        vecs[3] = '{10'h000, 10'h3FE, 10'h3FF, 2, 2, 11, 5'd0,  5'd0};
        vecs[4] = '{10'h17C, 10'h3FF, 10'h021, 1, 1,  7, 5'h1C, 5'h0B};

        reset = 1'b1; bus.start = 1'b1; bus.blk_ready = 1'b1;
        fill_rom(10'h021, 10'h043, 10'h3FF);
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.blk_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_fields", 32'({bus.blk_index, bus.blk_x, bus.blk_y}), 32'd0);
        reset = 1'b0; bus.start = 1'b0; bus.blk_ready = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fill_rom(vecs[v].w0, vecs[v].w1, vecs[v].w2);
            run_load(vecs[v].stall, 1'b0, cyc, acc, fx, fy);
            chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_accepts", v), 32'(acc), 32'(vecs[v].exp_cnt));
            chk($sformatf("v%0d_count", v), 32'(bus.count), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_cnt > 0) begin
                chk($sformatf("v%0d_first_x", v), 32'(fx), 32'(vecs[v].x0));
                chk($sformatf("v%0d_first_y", v), 32'(fy), 32'(vecs[v].y0));
            end
        end

        for (int i = 0; i < 32; i++) rom[i] = {5'(i * 3), 5'(i)};
        run_load(0, 1'b0, cyc, acc, fx, fy);
        chk("full_accepts", 32'(acc), 32'd32);
        chk("full_count", 32'(bus.count), 32'd32);
        chk("full_cycles", 32'(cyc), 32'd97);

        fill_rom(10'h021, 10'h043, 10'h3FF);
        run_load(0, 1'b1, cyc, acc, fx, fy);
        chk("poke_cycles", 32'(cyc), 32'd9);
        chk("poke_accepts", 32'(acc), 32'd2);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen = 1;
        end
        chk("poke_no_reload", 32'(seen), 32'd0);

        @(negedge clk);
        bus.start = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.blk_valid && bus.blk_index == 5'd1) seen = 1;
            bus.blk_ready = !(bus.blk_valid && bus.blk_index == 5'd1);
        end
        chk("reach_offer1", 32'(seen), 32'd1);
        reset = 1'b1;
        bus.blk_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", 32'(bus.blk_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_count", 32'(bus.count), 32'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_load(0, 1'b0, cyc, acc, fx, fy);
        chk("reload_cycles", 32'(cyc), 32'd9);
        chk("reload_count", 32'(bus.count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/block_loader.md
BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 Parameter WIDTH, default 10: the block position ROM word width; bits [WIDTH/2-1:0] hold X and bits [WIDTH-1:WIDTH/2] hold Y.
REQ-002 Parameter ADDR_WIDTH, default 5: the block position ROM address width; the table holds 2**ADDR_WIDTH entries.
REQ-003 Parameter TERMINATOR, default all-ones WIDTH bits: the end-of-list marker word.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: a one-cycle request to begin a level load.
REQ-007 Port rom_addr, output, ADDR_WIDTH: the registered address driven to the block position ROM.
REQ-008 Port rom_q, input, WIDTH: the ROM data, valid one clock after rom_addr is sampled.
REQ-009 Port blk_valid, output, 1: a block entry is offered downstream.
REQ-010 Port blk_ready, input, 1: downstream accepts the offered entry.
REQ-011 Port blk_index, output, ADDR_WIDTH: the ROM address of the offered entry.
REQ-012 Port blk_x, output, WIDTH/2: the X field of the offered entry.
REQ-013 Port blk_y, output, WIDTH/2: the Y field of the offered entry.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: a one-cycle pulse when a load completes.
REQ-016 Port count, output, ADDR_WIDTH+1: the number of entries accepted in the current or last load.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH, CAPTURE, OFFER and DONE.
REQ-018 In IDLE with start=1, the block SHALL set rom_addr=0 and count=0 and go to FETCH.
REQ-019 FETCH SHALL last exactly one cycle, holding rom_addr stable, and then go to CAPTURE.
REQ-020 In CAPTURE, if rom_q==TERMINATOR, the block SHALL go to DONE without asserting blk_valid.
REQ-021 In CAPTURE, if rom_q!=TERMINATOR, the block SHALL register blk_x, blk_y and blk_index=rom_addr, set blk_valid=1 and go to OFFER.
REQ-022 In OFFER, blk_valid, blk_x, blk_y and blk_index SHALL stay constant until the cycle in which blk_ready=1.
REQ-023 On the accept cycle (blk_valid&&blk_ready), the block SHALL increment count and clear blk_valid on the next edge.
REQ-024 On the accept cycle, if rom_addr==2**ADDR_WIDTH-1 the block SHALL go to DONE; otherwise it SHALL increment rom_addr and go to FETCH.
REQ-025 rom_addr SHALL NOT wrap to 0 within a load.
REQ-026 The minimum throughput SHALL be one entry per 3 cycles (FETCH, CAPTURE, OFFER) with blk_ready held high.
REQ-027 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE; count SHALL hold its value until the next start.
REQ-028 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-029 rom_q SHALL be ignored outside CAPTURE.
REQ-030 blk_ready SHALL be ignored while blk_valid=0.
REQ-031 blk_valid SHALL be high only in OFFER.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL enter IDLE with rom_addr=0, blk_valid=0, blk_index=0, blk_x=0, blk_y=0, busy=0, done=0 and count=0.
REQ-033 Reset SHALL take priority over start and blk_ready in the same cycle.
REQ-034 Reset asserted mid-load (any state) SHALL abort the load with no done pulse; the next start SHALL restart from address 0.

Verification
REQ-035 ROM with 0x021 at addr 0, 0x043 at addr 1, 0x3FF at addr 2; start with blk_ready=1 -> two accepts (x=1,y=1,idx=0), then (x=3,y=2,idx=1); done pulses; count=2; start-to-done is 9 cycles.
REQ-036 Same ROM, blk_ready low for 5 cycles during the first offer -> blk_valid and fields held stable for all 5 cycles; single accept; no duplicate entry or skipped entry.
REQ-037 All 32 ROM words are non-terminator -> 32 accepts with indices 0..31; done pulses after index 31; count=32; rom_addr never returns to 0.
REQ-038 addr 0 holds 0x3FF -> no blk_valid; done pulses 3 cycles after start; count=0.
REQ-039 Reset asserted during OFFER of index 1 -> blk_valid=0 and busy=0 on the next cycle with no done pulse; a later start reloads from index 0.
REQ-040 A start pulse during OFFER and a start pulse coincident with done -> both ignored; exactly one load completes.
